// File: rtl/tmr_pkg.sv
// Shared types and the bitwise majority helper for the TMR storage and its scrubber.
package tmr_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_VOTE,
        S_WRITE,
        S_WAIT
    } scrub_state_e;

    function automatic logic tmr_vote(
        input logic a,
        input logic b,
        input logic c
    );
        return (a & b) | (b & c) | (a & c);
    endfunction

endpackage

// File: rtl/tmr_vote3.sv
// Combinational W-bit majority voter with per-copy disagreement flags.
module tmr_vote3
    import tmr_pkg::*;
#(
    parameter int W = 12
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [W-1:0] voted,
    output logic [2:0]   mismatch
);

    always_comb begin
        voted = '0;
        for (int i = 0; i < W; i++) begin
            voted[i] = tmr_vote(a[i], b[i], c[i]);
        end
    end

    assign mismatch = {c != voted, b != voted, a != voted};

endmodule

// File: rtl/tmr_scrubber.sv
// Background scrubber: reads each triplicated word, votes, rewrites on disagreement.
module tmr_scrubber
    import tmr_pkg::*;
#(
    parameter int W        = 12,
    parameter int DEPTH    = 16,
    parameter int AW       = $clog2(DEPTH),
    parameter int CNT_W    = 16,
    parameter int INTERVAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr_cnt,
    output logic             req,
    input  logic             gnt,
    output logic             rd_en,
    output logic             wr_en,
    output logic [AW-1:0]    addr,
    input  logic [W-1:0]     rd_a,
    input  logic [W-1:0]     rd_b,
    input  logic [W-1:0]     rd_c,
    output logic [W-1:0]     wr_data,
    output logic             busy,
    output logic             pass_done,
    output logic [CNT_W-1:0] err_cnt,
    output logic [2:0]       copy_err,
    output logic [AW-1:0]    last_err_addr
);

    localparam int IW = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
    localparam logic [IW-1:0] WAIT_LAST = IW'((INTERVAL > 0) ? INTERVAL - 1 : 0);
    localparam logic [AW-1:0] PTR_LAST  = AW'(DEPTH - 1);

    scrub_state_e     r_state;
    scrub_state_e     w_next;
    scrub_state_e     w_resume;
    scrub_state_e     w_after;

    logic [AW-1:0]    r_ptr;
    logic [IW-1:0]    r_wait;
    logic [W-1:0]     r_voted;
    logic [CNT_W-1:0] r_err_cnt;
    logic [2:0]       r_copy_err;
    logic [AW-1:0]    r_last_addr;
    logic             r_pass_done;

    logic [W-1:0]     w_voted;
    logic [2:0]       w_mismatch;
    logic             w_diff;
    logic             w_fix;
    logic             w_advance;
    logic             w_wrap;

    tmr_vote3 #(
        .W(W)
    ) u_vote (
        .a        (rd_a),
        .b        (rd_b),
        .c        (rd_c),
        .voted    (w_voted),
        .mismatch (w_mismatch)
    );

    assign w_diff    = |w_mismatch;
    assign w_fix     = (r_state == S_VOTE) && w_diff;
    assign w_advance = ((r_state == S_VOTE) && !w_diff)
                    || ((r_state == S_WRITE) && gnt);
    assign w_wrap    = (r_ptr == PTR_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_resume = en ? S_READ : S_IDLE;
        w_after  = (INTERVAL > 0) ? S_WAIT : w_resume;
        w_next   = r_state;
        unique case (r_state)
            S_IDLE:  if (en) w_next = S_READ;
            S_READ:  if (gnt) w_next = S_VOTE;
            S_VOTE:  w_next = w_diff ? S_WRITE : w_after;
            S_WRITE: if (gnt) w_next = w_after;
            S_WAIT:  if (r_wait == WAIT_LAST) w_next = w_resume;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        req   = 1'b0;
        rd_en = 1'b0;
        wr_en = 1'b0;
        unique case (r_state)
            S_READ: begin
                req   = 1'b1;
                rd_en = 1'b1;
            end
            S_WRITE: begin
                req   = 1'b1;
                wr_en = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Pointer survives en dropping so a resumed scrub continues where it left off.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr       <= '0;
            r_wait      <= '0;
            r_pass_done <= 1'b0;
        end else begin
            r_pass_done <= w_advance && w_wrap;
            if (w_advance) begin
                r_ptr <= w_wrap ? '0 : r_ptr + 1'b1;
            end
            r_wait <= (r_state == S_WAIT) ? r_wait + 1'b1 : '0;
        end
    end

    // A same-cycle clear wins over the correction being counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_voted     <= '0;
            r_err_cnt   <= '0;
            r_copy_err  <= '0;
            r_last_addr <= '0;
        end else begin
            if (w_fix) begin
                r_voted     <= w_voted;
                r_last_addr <= r_ptr;
            end
            if (clr_cnt) begin
                r_err_cnt  <= '0;
                r_copy_err <= '0;
            end else if (w_fix) begin
                r_copy_err <= r_copy_err | w_mismatch;
                if (r_err_cnt != '1) begin
                    r_err_cnt <= r_err_cnt + 1'b1;
                end
            end
        end
    end

    assign busy          = (r_state != S_IDLE);
    assign addr          = r_ptr;
    assign wr_data       = r_voted;
    assign pass_done     = r_pass_done;
    assign err_cnt       = r_err_cnt;
    assign copy_err      = r_copy_err;
    assign last_err_addr = r_last_addr;

endmodule

// File: tb/tb_tmr_scrubber.sv
// Bench for tmr_scrubber: storage model, access-level reference model, directed scenarios.
module tb_tmr_scrubber;

    localparam int W     = 12;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          clr_cnt;
    logic          gnt;
    logic [W-1:0]  rd_a;
    logic [W-1:0]  rd_b;
    logic [W-1:0]  rd_c;

    logic          req;
    logic          rd_en;
    logic          wr_en;
    logic [AW-1:0] addr;
    logic [W-1:0]  wr_data;
    logic          busy;
    logic          pass_done;
    logic [15:0]   err_cnt;
    logic [2:0]    copy_err;
    logic [AW-1:0] last_err_addr;

    logic          req2;
    logic          rd_en2;
    logic          wr_en2;
    logic [AW-1:0] addr2;
    logic [W-1:0]  wr_data2;
    logic          busy2;
    logic          pass_done2;
    logic [1:0]    err_cnt2;
    logic [2:0]    copy_err2;
    logic [AW-1:0] last_err_addr2;

    always #5 clk = ~clk;

    tmr_scrubber #(
        .W(W), .DEPTH(DEPTH), .AW(AW), .CNT_W(16), .INTERVAL(0)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .clr_cnt(clr_cnt),
        .req(req), .gnt(gnt), .rd_en(rd_en), .wr_en(wr_en),
        .addr(addr), .rd_a(rd_a), .rd_b(rd_b), .rd_c(rd_c),
        .wr_data(wr_data), .busy(busy), .pass_done(pass_done),
        .err_cnt(err_cnt), .copy_err(copy_err),
        .last_err_addr(last_err_addr)
    );

    tmr_scrubber #(
        .W(W), .DEPTH(DEPTH), .AW(AW), .CNT_W(2), .INTERVAL(0)
    ) dut2 (
        .clk(clk), .rst(rst), .en(en), .clr_cnt(clr_cnt),
        .req(req2), .gnt(gnt), .rd_en(rd_en2), .wr_en(wr_en2),
        .addr(addr2), .rd_a(rd_a), .rd_b(rd_b), .rd_c(rd_c),
        .wr_data(wr_data2), .busy(busy2), .pass_done(pass_done2),
        .err_cnt(err_cnt2), .copy_err(copy_err2),
        .last_err_addr(last_err_addr2)
    );

    // Triplicated storage, driven by the first instance's port.
    logic [W-1:0]  mem_a [DEPTH];
    logic [W-1:0]  mem_b [DEPTH];
    logic [W-1:0]  mem_c [DEPTH];
    logic          inj;
    logic [AW-1:0] inj_addr;
    logic [W-1:0]  inj_a;
    logic [W-1:0]  inj_b;
    logic [W-1:0]  inj_c;
    int            cyc = 0;
    int            wr_cnt = 0;
    logic [AW-1:0] lw_addr = '0;
    logic [W-1:0]  lw_data = '0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (inj) begin
            mem_a[inj_addr] <= inj_a;
            mem_b[inj_addr] <= inj_b;
            mem_c[inj_addr] <= inj_c;
        end
        if (req && gnt && rd_en) begin
            rd_a <= mem_a[addr];
            rd_b <= mem_b[addr];
            rd_c <= mem_c[addr];
        end
        if (req && gnt && wr_en) begin
            mem_a[addr] <= wr_data;
            mem_b[addr] <= wr_data;
            mem_c[addr] <= wr_data;
            wr_cnt      <= wr_cnt + 1;
            lw_addr     <= addr;
            lw_data     <= wr_data;
        end
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: got timeout, expected event (cycle %0d)", name, cyc);
    endtask

    function automatic logic [W-1:0] maj3(
        input logic [W-1:0] a,
        input logic [W-1:0] b,
        input logic [W-1:0] c
    );
        logic [W-1:0] r;
        int n;
        r = '0;
        for (int i = 0; i < W; i++) begin
            n = int'(a[i]) + int'(b[i]) + int'(c[i]);
            r[i] = (n >= 2);
        end
        return r;
    endfunction

    // Reference model: the expected access sequence and the bookkeeping it implies.
    bit            m_live = 1'b0;
    logic          m_req  = 1'b0;
    logic          m_wr   = 1'b0;
    logic          m_vote = 1'b0;
    logic          m_pass = 1'b0;
    logic          m_fix;
    logic [AW-1:0] m_ptr   = '0;
    logic [AW-1:0] m_laddr = '0;
    logic [W-1:0]  m_wdata = '0;
    logic [W-1:0]  m_ca = '0;
    logic [W-1:0]  m_cb = '0;
    logic [W-1:0]  m_cc = '0;
    logic [W-1:0]  m_maj;
    logic [2:0]    m_cerr = '0;
    int            m_cnt  = 0;
    int            m_cnt2 = 0;

    task automatic cmp(
        input string         t,
        input logic          r,
        input logic          rd,
        input logic          wr,
        input logic [AW-1:0] a,
        input logic [W-1:0]  d,
        input logic          b,
        input logic          p,
        input int            cnt,
        input int            ecnt,
        input logic [2:0]    ce,
        input logic [AW-1:0] la
    );
        check({t, ".req"},   32'(r),  32'(m_req));
        check({t, ".rd_en"}, 32'(rd), 32'(m_req && !m_wr));
        check({t, ".wr_en"}, 32'(wr), 32'(m_req && m_wr));
        if (m_req) check({t, ".addr"}, 32'(a), 32'(m_ptr));
        if (m_req && m_wr) check({t, ".wr_data"}, 32'(d), 32'(m_wdata));
        check({t, ".busy"},      32'(b),  32'(m_req || m_vote));
        check({t, ".pass_done"}, 32'(p),  32'(m_pass));
        check({t, ".err_cnt"},   cnt,     ecnt);
        check({t, ".copy_err"},  32'(ce), 32'(m_cerr));
        check({t, ".last_err"},  32'(la), 32'(m_laddr));
    endtask

    task automatic m_advance();
        if (m_ptr == 4'd15) begin
            m_ptr  = '0;
            m_pass = 1'b1;
        end else begin
            m_ptr = m_ptr + 4'd1;
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (m_live) begin
                cmp("u0", req, rd_en, wr_en, addr, wr_data, busy, pass_done,
                    32'(err_cnt), m_cnt, copy_err, last_err_addr);
                cmp("u1", req2, rd_en2, wr_en2, addr2, wr_data2, busy2,
                    pass_done2, 32'(err_cnt2), m_cnt2, copy_err2,
                    last_err_addr2);
            end
            if (rst) begin
                m_live  = 1'b1;
                m_req   = 1'b0;
                m_wr    = 1'b0;
                m_vote  = 1'b0;
                m_pass  = 1'b0;
                m_ptr   = '0;
                m_laddr = '0;
                m_wdata = '0;
                m_cerr  = '0;
                m_cnt   = 0;
                m_cnt2  = 0;
            end else if (m_live) begin
                m_pass = 1'b0;
                m_fix  = m_vote && (m_ca != m_cb || m_cb != m_cc);
                m_maj  = maj3(m_ca, m_cb, m_cc);
                if (clr_cnt) begin
                    m_cnt  = 0;
                    m_cnt2 = 0;
                    m_cerr = '0;
                end else if (m_fix) begin
                    m_cnt  = (m_cnt < 65535) ? m_cnt + 1 : m_cnt;
                    m_cnt2 = (m_cnt2 < 3) ? m_cnt2 + 1 : m_cnt2;
                    m_cerr = m_cerr | {m_cc != m_maj, m_cb != m_maj,
                                       m_ca != m_maj};
                end
                if (m_fix) begin
                    m_laddr = m_ptr;
                    m_wdata = m_maj;
                end
                if (m_vote) begin
                    m_vote = 1'b0;
                    if (m_fix) begin
                        m_req = 1'b1;
                        m_wr  = 1'b1;
                    end else begin
                        m_advance();
                        m_req = en;
                        m_wr  = 1'b0;
                    end
                end else if (m_req) begin
                    if (gnt && m_wr) begin
                        m_advance();
                        m_req = en;
                        m_wr  = 1'b0;
                    end else if (gnt) begin
                        m_ca   = mem_a[m_ptr];
                        m_cb   = mem_b[m_ptr];
                        m_cc   = mem_c[m_ptr];
                        m_vote = 1'b1;
                        m_req  = 1'b0;
                    end
                end else begin
                    m_req = en;
                    m_wr  = 1'b0;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic inject(
        input logic [AW-1:0] a,
        input logic [W-1:0]  va,
        input logic [W-1:0]  vb,
        input logic [W-1:0]  vc
    );
        inj      = 1'b1;
        inj_addr = a;
        inj_a    = va;
        inj_b    = vb;
        inj_c    = vc;
        tick(1);
        inj = 1'b0;
    endtask

    task automatic clear();
        clr_cnt = 1'b1;
        tick(1);
        clr_cnt = 1'b0;
    endtask

    task automatic stop_idle();
        int k = 0;
        en = 1'b0;
        while (busy && k < 100) begin
            tick(1);
            k++;
        end
        if (busy) timeout("stop_idle");
    endtask

    task automatic wait_pass();
        int k = 0;
        tick(1);
        while (!pass_done && k < 100) begin
            tick(1);
            k++;
        end
        if (!pass_done) timeout("wait_pass");
    endtask

    task automatic wait_rd(input logic [AW-1:0] a);
        int k = 0;
        while (!(req && rd_en && addr == a) && k < 100) begin
            tick(1);
            k++;
        end
        if (!(req && rd_en && addr == a)) timeout("wait_rd");
    endtask

    task automatic wait_wr();
        int k = 0;
        while (!wr_en && k < 100) begin
            tick(1);
            k++;
        end
        if (!wr_en) timeout("wait_wr");
    endtask

    task automatic run_full();
        en = 1'b1;
        wait_pass();
        wait_pass();
        stop_idle();
    endtask

    int t0;
    int wb;

    initial begin
        rst      = 1'b1;
        en       = 1'b0;
        gnt      = 1'b1;
        clr_cnt  = 1'b0;
        inj      = 1'b0;
        inj_addr = '0;
        inj_a    = '0;
        inj_b    = '0;
        inj_c    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            inject(AW'(i), W'(i * 37 + 5), W'(i * 37 + 5), W'(i * 37 + 5));
        end
        tick(2);
        check("rst.req",       32'(req),           0);
        check("rst.busy",      32'(busy),          0);
        check("rst.addr",      32'(addr),          0);
        check("rst.wr_data",   32'(wr_data),       0);
        check("rst.err_cnt",   32'(err_cnt),       0);
        check("rst.copy_err",  32'(copy_err),      0);
        check("rst.last_err",  32'(last_err_addr), 0);
        rst = 1'b0;

        wb = wr_cnt;
        en = 1'b1;
        wait_pass();
        t0 = cyc;
        wait_pass();
        check("clean.pass_period", cyc - t0, 32);
        stop_idle();
        check("clean.writes",  wr_cnt - wb,   0);
        check("clean.err_cnt", 32'(err_cnt),  0);

        clear();
        wb = wr_cnt;
        inject(4'd5, 12'h0FF, 12'h0F0, 12'h0FF);
        run_full();
        check("flip.writes",   wr_cnt - wb,         1);
        check("flip.wr_addr",  32'(lw_addr),        5);
        check("flip.wr_data",  32'(lw_data),        32'h0FF);
        check("flip.err_cnt",  32'(err_cnt),        1);
        check("flip.copy_err", 32'(copy_err),       32'b010);
        check("flip.last_err", 32'(last_err_addr),  5);
        check("flip.mem_b",    32'(mem_b[5]),       32'h0FF);

        clear();
        inject(4'd9, 12'h001, 12'h002, 12'h003);
        run_full();
        check("two.wr_data",  32'(lw_data),  32'h003);
        check("two.copy_err", 32'(copy_err), 32'b011);
        check("two.mem_a",    32'(mem_a[9]), 32'h003);
        check("two.err_cnt",  32'(err_cnt),  1);

        clear();
        wb = wr_cnt;
        inject(4'd3, 12'h0AB, 12'h0AB, 12'h000);
        en = 1'b1;
        wait_rd(4'd3);
        gnt = 1'b0;
        repeat (4) begin
            tick(1);
            check("stall.rd_addr", 32'(addr),  3);
            check("stall.rd_en",   32'(rd_en), 1);
        end
        gnt = 1'b1;
        wait_wr();
        gnt = 1'b0;
        repeat (3) begin
            tick(1);
            check("stall.wr_addr", 32'(addr),  3);
            check("stall.wr_en",   32'(wr_en), 1);
        end
        gnt = 1'b1;
        stop_idle();
        check("stall.writes",   wr_cnt - wb,    1);
        check("stall.err_cnt",  32'(err_cnt),   1);
        check("stall.copy_err", 32'(copy_err),  32'b100);
        check("stall.mem_c",    32'(mem_c[3]),  32'h0AB);

        clear();
        wb = wr_cnt;
        for (int i = 0; i < 5; i++) begin
            inject(AW'(2 * i), 12'h155, 12'h155, 12'h955);
        end
        run_full();
        check("sat.writes",   wr_cnt - wb,     5);
        check("sat.err_cnt",  32'(err_cnt),    5);
        check("sat.err_cnt2", 32'(err_cnt2),   3);

        inject(4'd7, 12'h000, 12'h3C3, 12'h3C3);
        en = 1'b1;
        wait_rd(4'd7);
        tick(1);
        check("clr.in_vote", 32'(busy && !req), 1);
        clr_cnt = 1'b1;
        tick(1);
        clr_cnt = 1'b0;
        check("clr.err_cnt",  32'(err_cnt),       0);
        check("clr.err_cnt2", 32'(err_cnt2),      0);
        check("clr.copy_err", 32'(copy_err),      0);
        check("clr.last_err", 32'(last_err_addr), 7);
        check("clr.wr_en",    32'(wr_en),         1);
        stop_idle();
        check("clr.mem_a",    32'(mem_a[7]),      32'h3C3);

        inject(4'd11, 12'h456, 12'h456, 12'h457);
        en = 1'b1;
        wait_rd(4'd11);
        wait_wr();
        check("endrop.wr_addr", 32'(addr), 11);
        en = 1'b0;
        tick(1);
        check("endrop.busy",  32'(busy),      0);
        check("endrop.req",   32'(req),       0);
        check("endrop.mem_c", 32'(mem_c[11]), 32'h456);
        tick(1);
        en = 1'b1;
        tick(1);
        check("resume.rd_en", 32'(rd_en), 1);
        check("resume.addr",  32'(addr),  12);

        rst = 1'b1;
        tick(1);
        check("rstrd.req",       32'(req),           0);
        check("rstrd.rd_en",     32'(rd_en),         0);
        check("rstrd.wr_en",     32'(wr_en),         0);
        check("rstrd.busy",      32'(busy),          0);
        check("rstrd.addr",      32'(addr),          0);
        check("rstrd.wr_data",   32'(wr_data),       0);
        check("rstrd.pass_done", 32'(pass_done),     0);
        check("rstrd.err_cnt",   32'(err_cnt),       0);
        check("rstrd.copy_err",  32'(copy_err),      0);
        check("rstrd.last_err",  32'(last_err_addr), 0);
        rst = 1'b0;
        tick(1);
        check("rstrd.restart_rd",   32'(rd_en), 1);
        check("rstrd.restart_addr", 32'(addr),  0);
        stop_idle();
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
